// File: rtl/xadc_pkg.sv
// Shared constants for the XADC DRP reader: DRP addresses, data width and FSM encoding.
package xadc_pkg;

    localparam logic [6:0] ADDR_TEMP   = 7'h00;
    localparam logic [6:0] ADDR_VCCINT = 7'h01;
    localparam logic [6:0] ADDR_VCCAUX = 7'h02;

    localparam int DRP_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } drp_state_e;

endpackage

// File: rtl/xadc_drp_reader.sv
// DRP read initiator: one read per XADC end-of-conversion, with timeout and overrun flags.
//  state   | meaning
//  IDLE    | waiting for eoc_i; address latched on the starting edge
//  REQ     | den_o high for this single cycle
//  WAIT    | counting cycles until drdy_i or timeout
module xadc_drp_reader
    import xadc_pkg::*;
#(
    parameter logic [6:0] DRP_ADDR       = ADDR_TEMP,
    parameter bit         USE_CHANNEL    = 1'b0,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eoc_i,
    input  logic [4:0]        channel_i,
    output logic              den_o,
    output logic [6:0]        daddr_o,
    output logic              dwe_o,
    output logic [DRP_DW-1:0] di_o,
    input  logic              drdy_i,
    input  logic [DRP_DW-1:0] do_i,
    output logic [DRP_DW-1:0] dout,
    output logic              dout_valid,
    output logic              timeout_err,
    output logic              overrun,
    input  logic              clr_err_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    drp_state_e        state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic              den_nxt, valid_nxt, tmo_nxt, ovr_nxt;
    logic [6:0]        daddr_nxt;
    logic [DRP_DW-1:0] dout_nxt;

    assign dwe_o = 1'b0;
    assign di_o  = '0;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        den_nxt   = 1'b0;
        valid_nxt = 1'b0;
        daddr_nxt = daddr_o;
        dout_nxt  = dout;
        // Clear first so that a coincident set event below takes priority.
        tmo_nxt   = timeout_err & ~clr_err_i;
        ovr_nxt   = overrun & ~clr_err_i;
        case (state)
            ST_IDLE: begin
                if (eoc_i) begin
                    state_nxt = ST_REQ;
                    den_nxt   = 1'b1;
                    daddr_nxt = USE_CHANNEL ? {2'b00, channel_i} : DRP_ADDR;
                end
            end
            ST_REQ: begin
                state_nxt = ST_WAIT;
                timer_nxt = '0;
                if (eoc_i) ovr_nxt = 1'b1;
            end
            ST_WAIT: begin
                if (eoc_i) ovr_nxt = 1'b1;
                if (drdy_i) begin
                    dout_nxt  = do_i;
                    valid_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timer == TIMER_LAST) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timer != '1) begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            den_o       <= 1'b0;
            daddr_o     <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            den_o       <= den_nxt;
            daddr_o     <= daddr_nxt;
            dout        <= dout_nxt;
            dout_valid  <= valid_nxt;
            timeout_err <= tmo_nxt;
            overrun     <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Directed bench for xadc_drp_reader: a fixed-address and a channel-address instance share stimulus.
module tb_xadc_drp_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eoc = 1'b0;
    logic [4:0]  channel = 5'h00;
    logic        drdy = 1'b0;
    logic [15:0] do_data = 16'h0000;
    logic        clr = 1'b0;

    logic        den0, dwe0, dv0, tmo0, ovr0;
    logic [6:0]  daddr0;
    logic [15:0] di0, dout0;
    logic        den1, dwe1, dv1, tmo1, ovr1;
    logic [6:0]  daddr1;
    logic [15:0] di1, dout1;

    int vectors = 0;
    int miscompares = 0;
    int den_cnt = 0;
    int dv_cnt = 0;
    int ovr_seen = 0;

    always #5 clk = ~clk;

    xadc_drp_reader #(.DRP_ADDR(7'h00), .USE_CHANNEL(1'b0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .eoc_i(eoc), .channel_i(channel),
        .den_o(den0), .daddr_o(daddr0), .dwe_o(dwe0), .di_o(di0),
        .drdy_i(drdy), .do_i(do_data), .dout(dout0), .dout_valid(dv0),
        .timeout_err(tmo0), .overrun(ovr0), .clr_err_i(clr)
    );

    xadc_drp_reader #(.DRP_ADDR(7'h00), .USE_CHANNEL(1'b1), .TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .eoc_i(eoc), .channel_i(channel),
        .den_o(den1), .daddr_o(daddr1), .dwe_o(dwe1), .di_o(di1),
        .drdy_i(drdy), .do_i(do_data), .dout(dout1), .dout_valid(dv1),
        .timeout_err(tmo1), .overrun(ovr1), .clr_err_i(clr)
    );

    always @(posedge clk) begin
        if (den0 === 1'b1) den_cnt = den_cnt + 1;
        if (dv0 === 1'b1) dv_cnt = dv_cnt + 1;
        if (ovr0 === 1'b1) ovr_seen = ovr_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int den_ref, dv_ref;
        logic [15:0] rnd;

        // Reset values
        #12;
        chk("rst_den", {31'd0, den0}, 32'd0);
        chk("rst_daddr", {25'd0, daddr1}, 32'd0);
        chk("rst_dout", {16'd0, dout0}, 32'd0);
        chk("rst_flags", {28'd0, dv0, tmo0, ovr0, dwe0}, 32'd0);
        chk("rst_di", {16'd0, di0}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: normal read, drdy three cycles after den
        eoc = 1'b1;
        tick();                         // E0
        eoc = 1'b0;
        chk("t1_den_hi", {31'd0, den0}, 32'd1);
        chk("t1_daddr", {25'd0, daddr0}, 32'h00);
        tick();                         // E1 -> WAIT
        chk("t1_den_lo", {31'd0, den0}, 32'd0);
        tick();
        tick();
        drdy = 1'b1; do_data = 16'h9C40;
        tick();                         // E4 capture
        drdy = 1'b0; do_data = 16'h0000;
        chk("t1_dout", {16'd0, dout0}, 32'h9C40);
        chk("t1_valid", {31'd0, dv0}, 32'd1);
        tick();
        chk("t1_valid_drop", {31'd0, dv0}, 32'd0);
        chk("t1_dout_hold", {16'd0, dout0}, 32'h9C40);
        chk("t1_den_cnt", den_cnt, 32'd1);
        chk("t1_dv_cnt", dv_cnt, 32'd1);
        chk("t1_flags", {30'd0, tmo0, ovr0}, 32'd0);

        // 2: channel mode addressing
        channel = 5'h03; eoc = 1'b1;
        tick();
        eoc = 1'b0; channel = 5'h00;
        chk("t2_daddr_ch", {25'd0, daddr1}, 32'h03);
        chk("t2_daddr_fixed", {25'd0, daddr0}, 32'h00);
        tick();
        tick();
        chk("t2_daddr_hold", {25'd0, daddr1}, 32'h03);
        chk("t2_dwe", {31'd0, dwe1}, 32'd0);
        drdy = 1'b1; do_data = 16'h1234;
        tick();
        drdy = 1'b0;
        chk("t2_dout", {16'd0, dout1}, 32'h1234);
        chk("t2_dwe_end", {31'd0, dwe1}, 32'd0);
        tick();

        // 3: timeout, then a clean read
        dv_ref = dv_cnt;
        eoc = 1'b1;
        tick();                         // E0
        eoc = 1'b0;
        tick();                         // E1 -> WAIT
        repeat (7) tick();              // E8
        chk("t3_tmo_early", {31'd0, tmo0}, 32'd0);
        tick();                         // E9, timer hits TIMEOUT-1
        chk("t3_tmo_set", {31'd0, tmo0}, 32'd1);
        chk("t3_dout_kept", {16'd0, dout0}, 32'h1234);
        tick();
        chk("t3_no_valid", dv_cnt, dv_ref);
        den_ref = den_cnt;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        drdy = 1'b1; do_data = 16'h5A50;
        tick();
        drdy = 1'b0;
        chk("t3_after_dout", {16'd0, dout0}, 32'h5A50);
        chk("t3_after_den", den_cnt, den_ref + 1);
        tick();

        // 4: clear, overrun during WAIT, drdy on the timeout edge
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr_tmo", {31'd0, tmo0}, 32'd0);
        den_ref = den_cnt;
        eoc = 1'b1;
        tick();                         // E0
        eoc = 1'b0;
        tick();                         // E1
        tick();                         // E2
        eoc = 1'b1;
        tick();                         // E3, eoc in WAIT
        eoc = 1'b0;
        chk("t4_ovr_set", {31'd0, ovr0}, 32'd1);
        repeat (5) tick();              // E8
        drdy = 1'b1; do_data = 16'hBEE0;
        tick();                         // E9, drdy and timeout coincide
        drdy = 1'b0;
        chk("t4_race_dout", {16'd0, dout0}, 32'hBEE0);
        chk("t4_race_tmo", {31'd0, tmo0}, 32'd0);
        tick();
        chk("t4_no_second_den", den_cnt, den_ref + 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr_both", {30'd0, tmo0, ovr0}, 32'd0);
        eoc = 1'b1;
        tick();                         // E0
        eoc = 1'b0;
        tick();                         // E1
        tick();                         // E2
        eoc = 1'b1; clr = 1'b1;
        tick();                         // E3, set and clear together
        eoc = 1'b0; clr = 1'b0;
        chk("t4_ovr_set_wins", {31'd0, ovr0}, 32'd1);
        repeat (5) tick();              // E8
        clr = 1'b1;
        tick();                         // E9 timeout with clear
        clr = 1'b0;
        chk("t4_tmo_set_wins", {31'd0, tmo0}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr_final", {30'd0, tmo0, ovr0}, 32'd0);

        // 5: reset during WAIT, late drdy afterwards
        channel = 5'h1F; eoc = 1'b1;
        tick();
        eoc = 1'b0; channel = 5'h00;
        tick();
        tick();
        chk("t5_daddr_pre", {25'd0, daddr1}, 32'h1F);
        rst_n = 1'b0;
        #2;
        chk("t5_async_dout", {16'd0, dout0}, 32'd0);
        chk("t5_async_daddr", {25'd0, daddr1}, 32'd0);
        tick();
        rst_n = 1'b1;
        den_ref = den_cnt;
        dv_ref = dv_cnt;
        tick();
        drdy = 1'b1; do_data = 16'hABCD;
        tick();
        drdy = 1'b0;
        tick();
        tick();
        chk("t5_dout_zero", {16'd0, dout0}, 32'd0);
        chk("t5_no_valid", dv_cnt, dv_ref);
        chk("t5_no_den", den_cnt, den_ref);
        chk("t5_flags", {29'd0, tmo0, ovr0, den0}, 32'd0);

        // 6: back-to-back reads with random data
        dv_ref = dv_cnt;
        ovr_seen = 0;
        for (int i = 0; i < 100; i++) begin
            rnd = 16'($urandom);
            eoc = 1'b1;
            tick();
            eoc = 1'b0;
            tick();
            tick();
            tick();
            drdy = 1'b1; do_data = rnd;
            tick();
            drdy = 1'b0;
            chk("t6_dout", {16'd0, dout0}, {16'd0, rnd});
            repeat (95) tick();
        end
        chk("t6_dv_cnt", dv_cnt, dv_ref + 100);
        chk("t6_ovr", ovr_seen, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
